mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Iterative RV32M multiply/divide unit in the execute path.
- Consumes rs1Data/rs2Data read from the register file.
- Produces a single-cycle write-back triple (rdWrite, rdAddr, rdData) that drives the register file's write port directly.
- Issue logic stalls while busy is high.

Parameters:
- WIDTH, 32, operand/result width; must be 32 for RV32M semantics; the counter width is derived as clog2(WIDTH)+1.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  issue strobe; sampled only in IDLE.
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1Data  input  WIDTH  operand A, captured when start is accepted.
- rs2Data  input  WIDTH  operand B, captured when start is accepted.
- rdAddrIn  input  5  destination register, captured when start is accepted.
- busy  output  1  high from the cycle after acceptance through the DONE cycle, inclusive.
- done  output  1  one-cycle pulse in DONE.
- rdWrite  output  1  write-enable to the register file; one-cycle pulse.
- rdAddr  output  5  write address; valid while rdWrite is high.
- rdData  output  WIDTH  result; held until the next DONE.

Behaviour:
- Reset (asynchronous, any state):
  - state goes to IDLE.
  - busy, done, rdWrite, rdAddr, rdData and all internal registers go to 0.
  - An in-flight operation is discarded; no write occurs.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 latches operands, funct3 and rdAddrIn.
  - Signed ops convert operands to magnitudes and record result/remainder sign flags.
  - Next state is CALC with count=WIDTH, unless a fast path applies.
- Fast paths (IDLE goes directly to DONE, latency 1):
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU remainder = rs1Data.
  - Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- CALC multiply: radix-2 shift-add over a 2*WIDTH accumulator, one multiplier bit per cycle.
- CALC divide: restoring division, one quotient bit per cycle.
- CALC exit: count decrements each cycle; at count==1 the next state is DONE. CALC therefore lasts exactly WIDTH cycles.
- DONE:
  - Applies sign correction.
  - MUL returns the low half; MULH, MULHSU and MULHU return the high half.
  - MULHSU treats rs1 as signed and rs2 as unsigned.
  - Remainder sign follows the dividend.
  - Registers rdData and asserts done.
  - Asserts rdWrite only when the latched rd is not 0.
  - Next state is always IDLE.
- Latency:
  - start accepted at cycle N gives done at N+WIDTH+1 (33 for WIDTH=32).
  - The fast path gives done at N+1.
- Handshake:
  - start while busy is ignored; it is not queued.
  - Back-to-back issue: start may be asserted in the cycle after DONE, because busy is low in IDLE.
  - Inputs need only be valid in the acceptance cycle.
- Operands are not re-read after acceptance; a register-file write to rs1/rs2 during CALC does not affect the result.
- busy is registered, not combinational from start.

Optional Feature:
- Macro: MDU_MUL_FAST_EN.
- Defined:
  - Multiplies (funct3[2]=0) use a single combinational 33x33 signed multiply.
  - The product is registered directly into DONE, skipping CALC; latency is 1.
  - Divides are unchanged.
- Undefined:
  - All multiplies use the iterative path with latency WIDTH+1.
  - No hardware multiplier is inferred.

Test Plan:
- Reset mid-CALC: start MUL 7*6 to rd=5, assert rst at cycle 10 -> outputs 0 at once, no rdWrite ever; next start MUL 7*6 -> rdData=42, rdWrite with rdAddr=5 at start+33.
- MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000. MULHU same operands -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF. MUL 0x10000*0x10000 -> 0x00000000.
- DIV -7/2 -> 0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1). DIVU 100/7 -> 14. REMU 100/7 -> 2. Each at latency 33.
- DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, both with done at start+1. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; both at start+1.
- start held high for 40 cycles with MUL 3*3 to rd=0 -> done pulses at 33 and 67, rdWrite stays 0, busy drops only for the IDLE cycle between operations.
- With MDU_MUL_FAST_EN defined: MUL 123*456 -> 56088 at start+1; DIVU 100/7 still at start+33.

Source files
------------

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit; define MDU_MUL_FAST_EN for single-cycle multiplies
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] rs1Data,
    input  logic [WIDTH-1:0] rs2Data,
    input  logic [4:0]       rdAddrIn,
    output logic             busy,
    output logic             done,
    output logic             rdWrite,
    output logic [4:0]       rdAddr,
    output logic [WIDTH-1:0] rdData
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_op;
    logic [4:0]         r_rd;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               w_a_sgn, w_b_sgn, w_div0, w_ovf, w_fast, w_nq, w_nr;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_rem, w_quo, w_res;
    logic [WIDTH:0]     w_sum, w_diff;
    logic [2*WIDTH-1:0] w_fast_acc, w_step, w_fin, w_prod_c;
    logic [2:0]         w_op;
`ifdef MDU_MUL_FAST_EN
    logic signed [WIDTH:0] w_ma, w_mb;
    logic [2*WIDTH-1:0]    w_prod;
    assign w_ma   = {w_a_sgn, rs1Data};
    assign w_mb   = {w_b_sgn, rs2Data};
    assign w_prod = (2*WIDTH)'(w_ma) * (2*WIDTH)'(w_mb);
`endif

    // operand magnitudes, sign flags and fast-path detection for the op being issued
    always_comb begin
        w_a_sgn = rs1Data[WIDTH-1] && (funct3 == 3'b001 || funct3 == 3'b010 || (funct3[2] && !funct3[0]));
        w_b_sgn = rs2Data[WIDTH-1] && (funct3 == 3'b001 || (funct3[2] && !funct3[0]));
        w_a_mag = w_a_sgn ? -rs1Data : rs1Data;
        w_b_mag = w_b_sgn ? -rs2Data : rs2Data;
        w_div0  = funct3[2] && rs2Data == '0;
        w_ovf   = funct3[2] && !funct3[0] && rs1Data == MIN_NEG && rs2Data == '1;
`ifdef MDU_MUL_FAST_EN
        w_fast     = w_div0 || w_ovf || !funct3[2];
        w_fast_acc = !funct3[2] ? w_prod : w_div0 ? {rs1Data, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, MIN_NEG};
`else
        w_fast     = w_div0 || w_ovf;
        w_fast_acc = w_div0 ? {rs1Data, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, MIN_NEG};
`endif
    end

    // one shift-add multiply step or one restoring-divide step on the accumulator
    always_comb begin
        w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_acc[0] ? r_b : {WIDTH{1'b0}}};
        w_diff = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_b};
        w_step = !r_op[2] ? {w_sum, r_acc[WIDTH-1:1]} :
                 !w_diff[WIDTH] ? {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1} : {r_acc[2*WIDTH-2:0], 1'b0};
    end

    // pick the final accumulator (fast path or last step) and apply sign correction
    always_comb begin
        w_op     = r_state == IDLE ? funct3 : r_op;
        w_nq     = r_state == IDLE ? 1'b0 : r_neg_q;
        w_nr     = r_state == IDLE ? 1'b0 : r_neg_r;
        w_fin    = r_state == IDLE ? w_fast_acc : w_step;
        w_prod_c = w_nq ? -w_fin : w_fin;
        w_rem    = w_nr ? -w_fin[2*WIDTH-1:WIDTH] : w_fin[2*WIDTH-1:WIDTH];
        w_quo    = w_nq ? -w_fin[WIDTH-1:0] : w_fin[WIDTH-1:0];
        w_res    = !w_op[2] ? (w_op[1:0] == 2'b00 ? w_prod_c[WIDTH-1:0] : w_prod_c[2*WIDTH-1:WIDTH]) :
                   w_op[1] ? w_rem : w_quo;
    end

    // control FSM; outputs are registered on entry to DONE so they are visible during DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_rd    <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdWrite <= 1'b0;
            rdAddr  <= '0;
            rdData  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    done    <= 1'b0;
                    rdWrite <= 1'b0;
                    if (start) begin
                        busy    <= 1'b1;
                        r_op    <= funct3;
                        r_rd    <= rdAddrIn;
                        r_neg_q <= w_a_sgn ^ w_b_sgn;
                        r_neg_r <= w_a_sgn;
                        if (w_fast) begin
                            r_state <= DONE;
                            done    <= 1'b1;
                            rdWrite <= rdAddrIn != 5'd0;
                            rdAddr  <= rdAddrIn;
                            rdData  <= w_res;
                        end else begin
                            r_state <= CALC;
                            r_cnt   <= CW'(WIDTH);
                            r_b     <= funct3[2] ? w_b_mag : w_a_mag;
                            r_acc   <= {{WIDTH{1'b0}}, funct3[2] ? w_a_mag : w_b_mag};
                        end
                    end
                end
                CALC: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= DONE;
                        done    <= 1'b1;
                        rdWrite <= r_rd != 5'd0;
                        rdAddr  <= r_rd;
                        rdData  <= w_res;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    rdWrite <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: randomized scoreboard bench for mdu_iter against an arithmetic RV32M model
module tb_mdu_iter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1Data = '0;
    logic [31:0] rs2Data = '0;
    logic [4:0]  rdAddrIn = '0;
    logic        busy, done, rdWrite;
    logic [4:0]  rdAddr;
    logic [31:0] rdData;

    mdu_iter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .rs1Data(rs1Data), .rs2Data(rs2Data), .rdAddrIn(rdAddrIn),
        .busy(busy), .done(done), .rdWrite(rdWrite), .rdAddr(rdAddr), .rdData(rdData)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;
    exp_t sbq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        logic [31:0] r;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        p   = {32'd0, a} * {32'd0, b};
        case (op)
            3'd0: r = p[31:0];
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * longint'({32'd0, b}); r = p[63:32]; end
            3'd3: r = p[63:32];
            3'd4: r = b == 0 ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            3'd5: r = b == 0 ? 32'hFFFF_FFFF : a / b;
            3'd6: r = b == 0 ? a : ovf ? 32'd0 : 32'(sa % sb);
            default: r = b == 0 ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic fast;
        fast = (op[2] && b == 0) || ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef MDU_MUL_FAST_EN
        fast = fast || !op[2];
`endif
        return fast ? 0 : 32;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // monitor: every done pops one expected write-back
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (done) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: rdData %0h rdAddr %0d at cycle %0d", rdData, rdAddr, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("latency", 64'(cyc), 64'(e.cyc));
                    chk("rdData", 64'(rdData), 64'(e.data));
                    chk("rdWrite", 64'(rdWrite), 64'(e.rd != 0));
                    if (e.rd != 0) chk("rdAddr", 64'(rdAddr), 64'(e.rd));
                end
            end else if (rdWrite) begin
                checks++;
                errors++;
                $display("FAIL stray_rdWrite: rdWrite 1 without done at cycle %0d", cyc);
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        @(negedge clk);
        start = 1'b1; funct3 = op; rs1Data = a; rs2Data = b; rdAddrIn = rd;
        sbq.push_back(exp_t'{cyc + 1 + ref_lat(op, a, b), rd, ref_res(op, a, b)});
        @(negedge clk);
        start = 1'b0; funct3 = 3'($urandom); rs1Data = $urandom; rs2Data = $urandom; rdAddrIn = 5'($urandom);
        wait_idle();
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int ndone, acc_edge, last_acc, busy_end, lat;
        repeat (2) @(negedge clk);
        chk("reset_state", 64'({busy, done, rdWrite, rdAddr, rdData}), 64'd0);
        rst = 1'b0;

        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3);
        run_op(3'd0, 32'h0001_0000, 32'h0001_0000, 5'd4);
        run_op(3'd4, -32'sd7, 32'd2, 5'd5);
        run_op(3'd6, -32'sd7, 32'd2, 5'd6);
        run_op(3'd5, 32'd100, 32'd7, 5'd7);
        run_op(3'd7, 32'd100, 32'd7, 5'd8);
        run_op(3'd4, 32'd5, 32'd0, 5'd9);
        run_op(3'd7, 32'd5, 32'd0, 5'd10);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        run_op(3'd0, 32'd123, 32'd456, 5'd13);

        // reset while a multiply is in flight: nothing may ever be written back
        run_op(3'd5, 32'd100, 32'd7, 5'd3);
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; rs1Data = 32'd7; rs2Data = 32'd6; rdAddrIn = 5'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("busy_before_reset", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1 chk("reset_async", 64'({busy, done, rdWrite, rdAddr, rdData}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || rdWrite) ndone++;
        end
        chk("no_write_after_reset", 64'(ndone), 64'd0);
        run_op(3'd0, 32'd7, 32'd6, 5'd5);

        // start held high: ops chain with a single idle cycle between them
        lat = ref_lat(3'd0, 32'd3, 32'd3);
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; rs1Data = 32'd3; rs2Data = 32'd3; rdAddrIn = 5'd0;
        acc_edge = cyc + 1;
        last_acc = -10;
        busy_end = -10;
        for (int i = 0; i < 40; i++) begin
            if (cyc + 1 == acc_edge) begin
                sbq.push_back(exp_t'{acc_edge + lat, 5'd0, 32'd9});
                last_acc = acc_edge;
                busy_end = acc_edge + lat;
                acc_edge = acc_edge + lat + 2;
            end
            @(negedge clk);
            chk("b2b_busy", 64'(busy), 64'(cyc >= last_acc && cyc <= busy_end));
        end
        start = 1'b0;
        wait_idle();

        for (int i = 0; i < 60; i++) run_op(3'($urandom), pick(), pick(), 5'($urandom));

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
